// File: rtl/neopixel_rx.sv
// Purpose : WS2812 NeoPixel line decoder; classifies high-pulse widths into bits,
//           packs MSB-first 24-bit pixel words and detects the frame latch gap.
// Latency : 3 CLOCK_50 edges from raw line edge to strobe (2 sync flops + 1 output reg).
// Backpressure: none; the line is free-running, so strobes are single-cycle and must be
//           consumed on the cycle they appear.
// Ports   : CLOCK_50 / reset_n (sync, active-low); neopixel_data raw async line;
//           pixel_data/pixel_valid/pixel_index word output; frame_done, frame_error
//           strobes; busy while a frame is being decoded.
// Option  : define NP_RX_LEN_CHECK_EN to flag frames whose pixel count != EXP_PIXELS.
module neopixel_rx #(
  parameter int T_GLITCH   = 6,
  parameter int T_THRESH   = 27,
  parameter int T_HIGH_MAX = 60,
  parameter int T_LATCH    = 1250,
  parameter int EXP_PIXELS = 16
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        neopixel_data,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [11:0] GLITCH_C = 12'(T_GLITCH);
  localparam logic [11:0] THRESH_C = 12'(T_THRESH);
  localparam logic [11:0] HMAX_C   = 12'(T_HIGH_MAX);
  localparam logic [11:0] LATCH_C  = 12'(T_LATCH);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state, state_nxt;
  logic        sync_ff, line_s, line_d;
  logic        rise, fall;
  logic [11:0] run_cnt;
  logic [22:0] shreg;
  logic [4:0]  bit_cnt;
  logic [7:0]  pix_cnt;

  // decoder control, produced by the output process
  logic        latch_hit;
  logic        bit_val;
  logic        shift_en;
  logic        word_done;
  logic        done_set;
  logic        err_set;
  logic        clr_frame;

  // ---------------- line synchronizer and edge detect ----------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync_ff <= 1'b0;
      line_s  <= 1'b0;
      line_d  <= 1'b0;
    end else begin
      sync_ff <= neopixel_data;
      line_s  <= sync_ff;
      line_d  <= line_s;
    end
  end

  assign rise = line_s & ~line_d;
  assign fall = ~line_s & line_d;

  // Run length of the current level. On the cycle an edge is seen, run_cnt
  // still holds the full length of the level that just ended.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n)
      run_cnt <= '0;
    else if (rise || fall)
      run_cnt <= 12'd1;
    else if (run_cnt != 12'hFFF)
      run_cnt <= run_cnt + 12'd1;
  end

  // line_d low means run_cnt is measuring a low run, even on a rise cycle,
  // so a rise coincident with the latch count still completes the latch.
  assign latch_hit = ~line_d && (run_cnt >= LATCH_C);
  assign bit_val   = (run_cnt >= THRESH_C);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n)
      state <= SYNC;
    else
      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC: if (latch_hit) state_nxt = rise ? HIGH : IDLE;
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: begin
        if (run_cnt > HMAX_C)
          state_nxt = SYNC;
        else if (fall)
          state_nxt = (run_cnt < GLITCH_C) ? SYNC : LOW;
      end
      LOW: begin
        if (latch_hit)
          state_nxt = rise ? HIGH : IDLE;
        else if (rise)
          state_nxt = HIGH;
      end
      default: state_nxt = SYNC;
    endcase
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    shift_en  = 1'b0;
    done_set  = 1'b0;
    err_set   = 1'b0;
    clr_frame = 1'b0;
    case (state)
      HIGH: begin
        if (run_cnt > HMAX_C) begin
          err_set   = 1'b1;
          clr_frame = 1'b1;
        end else if (fall) begin
          if (run_cnt < GLITCH_C) begin
            err_set   = 1'b1;
            clr_frame = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end
      end
      LOW: begin
        if (latch_hit) begin
          done_set  = 1'b1;
          clr_frame = 1'b1;
          if (bit_cnt != 5'd0)
            err_set = 1'b1;
`ifdef NP_RX_LEN_CHECK_EN
          if (pix_cnt != 8'(EXP_PIXELS))
            err_set = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign word_done = shift_en && (bit_cnt == 5'd23);

`ifndef NP_RX_LEN_CHECK_EN
  // Pixel count is tracked but not compared against EXP_PIXELS in this build.
  logic unused_len;
  assign unused_len = (pix_cnt == 8'(EXP_PIXELS));
`endif

  // ---------------- datapath and registered outputs ----------------
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= done_set;
      frame_error <= err_set;
      if (clr_frame) begin
        bit_cnt <= '0;
        pix_cnt <= '0;
      end else if (shift_en) begin
        shreg <= {shreg[21:0], bit_val};
        if (word_done) begin
          pixel_data  <= {shreg, bit_val};
          pixel_valid <= 1'b1;
          pixel_index <= pix_cnt;
          pix_cnt     <= pix_cnt + 8'd1;
          bit_cnt     <= '0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
    end
  end

  assign busy = (state == HIGH) || (state == LOW);

endmodule

// File: tb/tb_neopixel_rx.sv
module tb_neopixel_rx;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        neopixel_data;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic        frame_error;
  logic        busy;

`ifdef NP_RX_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  neopixel_rx dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .neopixel_data (neopixel_data),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .pixel_index   (pixel_index),
    .frame_done    (frame_done),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // observed strobes, sampled on the falling edge
  logic [31:0] pv_q[$];
  int          pv_cyc[$];
  int          fd_cyc[$];
  int          fe_cyc[$];

  always @(negedge CLOCK_50) begin
    if (pixel_valid) begin
      pv_q.push_back({pixel_index, pixel_data});
      pv_cyc.push_back(cyc);
    end
    if (frame_done)  fd_cyc.push_back(cyc);
    if (frame_error) fe_cyc.push_back(cyc);
  end

  // model: pixel words the frame is built from, in order
  logic [23:0] exp_w[$];
  int n_chk  = 0;
  int n_fail = 0;
  int last_fall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    end
  endtask

  task automatic drive(input logic v, input int n);
    neopixel_data = v;
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic send_bit(input int h, input int l);
    drive(1'b1, h);
    last_fall = cyc;
    drive(1'b0, l);
  endtask

  // mode 0: reference transmitter timing; mode 1: random legal widths incl. edges
  function automatic int hi_width(input logic b, input int mode);
    int sel;
    if (mode == 0) return b ? 35 : 18;
    sel = int'($urandom_range(0, 2));
    if (b) return (sel == 0) ? 27 : (sel == 1) ? 60 : int'($urandom_range(27, 60));
    return (sel == 0) ? 6 : (sel == 1) ? 26 : int'($urandom_range(6, 26));
  endfunction

  function automatic int lo_width(input logic b, input int mode);
    if (mode == 0) return b ? 30 : 40;
    return int'($urandom_range(6, 30));
  endfunction

  task automatic send_word(input logic [23:0] w, input int nbits, input int mode);
    for (int b = 23; b >= 24 - nbits; b--)
      send_bit(hi_width(w[b], mode), lo_width(w[b], mode));
  endtask

  task automatic clear_obs();
    pv_q.delete();
    pv_cyc.delete();
    fd_cyc.delete();
    fe_cyc.delete();
    exp_w.delete();
  endtask

  task automatic check_frame(input string tag, input int req_fd, input int req_fe);
    chk({tag, "_npix"}, pv_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < pv_q.size(); i++)
      chk({tag, "_pix"}, pv_q[i], {8'(i), exp_w[i]});
    chk({tag, "_nfd"}, fd_cyc.size(), req_fd);
    chk({tag, "_nfe"}, fe_cyc.size(), req_fe);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  pixel_data,  0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_index"}, pixel_index, 0);
    chk({tag, "_done"},  frame_done,  0);
    chk({tag, "_err"},   frame_error, 0);
    chk({tag, "_busy"},  busy,        0);
  endtask

  logic [23:0] w;
  int          npix;
  int          one_px_fe;

  initial begin
    one_px_fe = LEN_EN ? 1 : 0;   // any frame with a pixel count other than 16

    // reset state
    reset_n       = 1'b0;
    neopixel_data = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    drive(1'b0, 1300);

    // loopback: 16 x FF0000 with reference timing
    clear_obs();
    for (int p = 0; p < 16; p++) begin
      exp_w.push_back(24'hFF0000);
      send_word(24'hFF0000, 24, 0);
    end
    drive(1'b0, 1300);
    check_frame("loop", 1, 0);
    chk("loop_pv_lat", (pv_cyc.size() > 0) ? pv_cyc[pv_cyc.size()-1] - last_fall : -1, 3);
    chk("loop_fd_lat", (fd_cyc.size() > 0) ? fd_cyc[0] - last_fall : -1, 1253);
    chk("loop_hold", pixel_data, 24'hFF0000);

    // threshold: alternating 26/27 highs, first bit 0
    clear_obs();
    exp_w.push_back(24'h555555);
    for (int i = 0; i < 24; i++) send_bit((i % 2) ? 27 : 26, 30);
    drive(1'b0, 1300);
    check_frame("thresh", 1, one_px_fe);

    // boundary widths 6,26 -> 0 and 27,60 -> 1, repeated
    clear_obs();
    exp_w.push_back(24'h333333);
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: send_bit(6, 20);
        1: send_bit(26, 20);
        2: send_bit(27, 20);
        default: send_bit(60, 20);
      endcase
    end
    drive(1'b0, 1300);
    check_frame("bound", 1, one_px_fe);

    // partial pixel: done and error coincide, no pixel
    clear_obs();
    send_word(24'($urandom), 12, 1);
    drive(1'b0, 1300);
    check_frame("partial", 1, 1);
    chk("partial_coinc", (fe_cyc.size() > 0) ? fe_cyc[0] : -1,
        (fd_cyc.size() > 0) ? fd_cyc[0] : -2);

    // glitch after 10 bits, then a frame that must be ignored until resync
    clear_obs();
    send_word(24'($urandom), 10, 1);
    drive(1'b1, 3);
    drive(1'b0, 3);
    chk("glitch_err", frame_error, 1);
    chk("glitch_busy", busy, 0);
    drive(1'b0, 30);
    send_word(24'($urandom), 24, 0);
    drive(1'b0, 1300);
    check_frame("glitch", 0, 1);
    clear_obs();
    w = 24'($urandom);
    exp_w.push_back(w);
    send_word(w, 24, 1);
    drive(1'b0, 1300);
    check_frame("glitch_resync", 1, one_px_fe);

    // overlong high
    clear_obs();
    send_word(24'($urandom), 5, 1);
    drive(1'b1, 61);
    drive(1'b0, 1300);
    check_frame("overlong", 0, 1);

    // reset mid-frame
    send_word(24'($urandom), 10, 0);
    reset_n = 1'b0;
    @(posedge CLOCK_50);
    #1;
    check_all_zero("midrst");
    reset_n = 1'b1;
    clear_obs();
    send_word(24'($urandom), 24, 0);
    drive(1'b0, 1300);
    w = 24'($urandom);
    exp_w.push_back(w);
    send_word(w, 24, 0);
    drive(1'b0, 1300);
    check_frame("midrst_frame", 1, one_px_fe);

    // random short frames
    for (int f = 0; f < 2; f++) begin
      clear_obs();
      npix = int'($urandom_range(1, 3));
      for (int p = 0; p < npix; p++) begin
        w = 24'($urandom);
        exp_w.push_back(w);
        send_word(w, 24, 1);
      end
      drive(1'b0, 1300);
      check_frame("rand", 1, one_px_fe);
    end

    // 15-pixel frame: length error only when the count check is built in
    clear_obs();
    for (int p = 0; p < 15; p++) begin
      w = 24'($urandom);
      exp_w.push_back(w);
      send_word(w, 24, 1);
    end
    drive(1'b0, 1300);
    check_frame("len15", 1, one_px_fe);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
